div_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one restoring divider (`divrest`) among NREQ requesters.
- Selects a requester, drives the divider's M/Q/start inputs, and tracks the divider's busy output.
- Captures the quotient and remainder from the divider's outbus, then returns them to the winning requester with a one-cycle done pulse.
- Sits between client blocks and the single `divrest` instance.

---
 rtl/div_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_div_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing one restoring divider among NREQ clients.
// Optional: define DIV_ARBITER_ZERO_CHECK_EN to short-circuit zero divisors with err=1.
module div_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_m,
    input  logic [NREQ*W-1:0] req_q,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      res_quo,
    output logic [W-1:0]      res_rem,
    output logic              err,
    output logic              div_start,
    input  logic              div_busy,
    output logic [W-1:0]      div_m,
    output logic [W-1:0]      div_q,
    input  logic [W-1:0]      div_outbus
);
    // state     | meaning
    // IDLE      | arbitrate; latch winner operands and grant
    // START     | raise div_start
    // WAIT_BUSY | hold div_start until divider reports busy
    // WAIT_DONE | wait for busy to fall; outbus carries quotient
    // CAP_REM   | outbus carries remainder
    // DONE      | one-cycle done pulse to winner, advance pointer

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        CAP_REM,
        DONE
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   ptr, ptr_d;
    logic [IW-1:0]   win, win_d;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [NREQ-1:0] gnt_d;
    logic            div_start_d;
    logic [W-1:0]    div_m_d, div_q_d;
    logic [W-1:0]    quo_cap, quo_cap_d;
    logic [W-1:0]    res_quo_d, res_rem_d;
    logic [W-1:0]    pick_m, pick_q;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // First set request scanning upward from ptr, wrapping at NREQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_vld && req[wrap_add(ptr, k)]) begin
                pick     = wrap_add(ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_m = req_m[int'(pick)*W +: W];
    assign pick_q = req_q[int'(pick)*W +: W];
    assign done   = (state == DONE) ? gnt : '0;

`ifdef DIV_ARBITER_ZERO_CHECK_EN
    logic err_r, err_d;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        win_d       = win;
        gnt_d       = gnt;
        div_start_d = div_start;
        div_m_d     = div_m;
        div_q_d     = div_q;
        quo_cap_d   = quo_cap;
        res_quo_d   = res_quo;
        res_rem_d   = res_rem;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
        err_d       = err_r;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    win_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                    div_m_d = pick_m;
                    div_q_d = pick_q;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
                    if (pick_m == '0) begin
                        res_quo_d = '1;
                        res_rem_d = pick_q;
                        err_d     = 1'b1;
                        state_d   = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = START;
                    end
`else
                    state_d = START;
`endif
                end
            end
            START: begin
                div_start_d = 1'b1;
                state_d     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (div_busy) begin
                    div_start_d = 1'b0;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!div_busy) begin
                    quo_cap_d = div_outbus;
                    state_d   = CAP_REM;
                end
            end
            CAP_REM: begin
                // Results are published together so they stay stable until the next done.
                res_quo_d = quo_cap;
                res_rem_d = div_outbus;
                state_d   = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = wrap_add(win, 1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            gnt       <= '0;
            div_start <= 1'b0;
            div_m     <= '0;
            div_q     <= '0;
            quo_cap   <= '0;
            res_quo   <= '0;
            res_rem   <= '0;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
            err_r     <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            win       <= win_d;
            gnt       <= gnt_d;
            div_start <= div_start_d;
            div_m     <= div_m_d;
            div_q     <= div_q_d;
            quo_cap   <= quo_cap_d;
            res_quo   <= res_quo_d;
            res_rem   <= res_rem_d;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
            err_r     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divrest model (busy length/delay adjustable).
module tb_div_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_m, req_q;
    logic [NREQ-1:0]   gnt, done;
    logic [W-1:0]      res_quo, res_rem;
    logic              err;
    logic              div_start, div_busy;
    logic [W-1:0]      div_m, div_q, div_outbus;

    typedef struct {
        int         idx;
        logic [7:0] quo;
        logic [7:0] rem;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int busy_len = 9;
    int busy_dly = 1;
    int dly_cnt, run_cnt;
    logic phase, start_prev;
    logic [W-1:0] m_quo, m_rem;
    int n_accept = 0, n_rise = 0, n_start_hi = 0, n_multi_gnt = 0;

    div_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_m      (req_m),
        .req_q      (req_q),
        .gnt        (gnt),
        .done       (done),
        .res_quo    (res_quo),
        .res_rem    (res_rem),
        .err        (err),
        .div_start  (div_start),
        .div_busy   (div_busy),
        .div_m      (div_m),
        .div_q      (div_q),
        .div_outbus (div_outbus)
    );

    always #5 clk = ~clk;

    // Divider model: busy rises busy_dly start-sampling edges after start, stays high busy_len
    // cycles, then outbus shows quotient for one cycle and remainder the next.
    always @(posedge clk) begin
        if (reset) begin
            div_busy   <= 1'b0;
            phase      <= 1'b0;
            dly_cnt    <= 0;
            run_cnt    <= 0;
            div_outbus <= '0;
            start_prev <= 1'b0;
        end else begin
            start_prev <= div_start;
            if (div_start && !start_prev) n_rise <= n_rise + 1;
            if (div_start) n_start_hi <= n_start_hi + 1;
            if ($countones(gnt) > 1) n_multi_gnt <= n_multi_gnt + 1;
            if (phase) begin
                div_outbus <= m_rem;
                phase      <= 1'b0;
            end else if (div_busy) begin
                if (run_cnt == 0) begin
                    div_busy   <= 1'b0;
                    div_outbus <= m_quo;
                    phase      <= 1'b1;
                end else begin
                    run_cnt <= run_cnt - 1;
                end
            end else if (div_start) begin
                if (dly_cnt + 1 >= busy_dly) begin
                    div_busy <= 1'b1;
                    run_cnt  <= busy_len - 1;
                    dly_cnt  <= 0;
                    n_accept <= n_accept + 1;
                    if (div_m == '0) begin
                        m_quo <= '1;
                        m_rem <= div_q;
                    end else begin
                        m_quo <= div_q / div_m;
                        m_rem <= div_q % div_m;
                    end
                end else begin
                    dly_cnt <= dly_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] m, input logic [7:0] q);
        req_m[i*W +: W] = m;
        req_q[i*W +: W] = q;
    endtask

    task automatic push(input int i, input logic [7:0] quo, input logic [7:0] rem, input logic e);
        exp_t x;
        x.idx = i;
        x.quo = quo;
        x.rem = rem;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait for nops done pulses, comparing each against the scoreboard head.
    task automatic run_ops(input int nops, input bit drop, output int lat);
        int seen;
        int cyc;
        exp_t x;
        logic [NREQ-1:0] v;
        seen = 0;
        cyc  = 0;
        lat  = -1;
        while (seen < nops && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                if (lat < 0) lat = cyc;
                if (sb.size() == 0) begin
                    check("sb_empty", 32'(done), 0);
                end else begin
                    x = sb.pop_front();
                    v = NREQ'(1) << x.idx;
                    check("done_vec", 32'(done), 32'(v));
                    check("res_quo", 32'(res_quo), 32'(x.quo));
                    check("res_rem", 32'(res_rem), 32'(x.rem));
                    check("err", 32'(err), 32'(x.err));
                end
                if (drop) req = req & ~done;
                seen++;
            end
        end
        if (seen < nops) check("done_timeout", seen, nops);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int r0, h0, a0;
        bit found;

        reset = 1'b1;
        req   = '0;
        req_m = '0;
        req_q = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_start", 32'(div_start), 0);
        check("rst_opnd", {div_m, div_q}, 0);
        check("rst_res", {res_quo, res_rem}, 0);
        check("rst_err", 32'(err), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single request, divider busy 9 cycles.
        busy_len = 9;
        busy_dly = 1;
        set_op(0, 8'd4, 8'd14);
        push(0, 8'd3, 8'd2, 1'b0);
        r0  = n_rise;
        h0  = n_start_hi;
        req = 4'b0001;
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'(4'b0001));
        check("single_div_m", 32'(div_m), 4);
        check("single_div_q", 32'(div_q), 14);
        run_ops(1, 1'b1, lat);
        check("single_latency", lat + 1, 14);
        check("single_start_rise", n_rise - r0, 1);
        check("single_start_hi", n_start_hi - h0, 2);

        // Round robin with all requesters held.
        do_reset();
        busy_len = 3;
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'd20);
        push(0, 8'd20, 8'd0, 1'b0);
        push(1, 8'd10, 8'd0, 1'b0);
        push(2, 8'd6, 8'd2, 1'b0);
        push(3, 8'd5, 8'd0, 1'b0);
        push(0, 8'd20, 8'd0, 1'b0);
        req = 4'b1111;
        run_ops(5, 1'b0, lat);
        req = '0;
        repeat (2) @(negedge clk);

        // Late request while requester 1 is in flight; requester 1 also drops early.
        set_op(1, 8'd3, 8'd7);
        set_op(2, 8'd5, 8'd17);
        push(1, 8'd2, 8'd1, 1'b0);
        push(2, 8'd3, 8'd2, 1'b0);
        req = 4'b0010;
        repeat (3) @(negedge clk);
        check("late_gnt1", 32'(gnt), 32'(4'b0010));
        req = 4'b0100;
        @(negedge clk);
        check("late_gnt_hold", 32'(gnt), 32'(4'b0010));
        run_ops(2, 1'b1, lat);
        check("gnt_onehot", n_multi_gnt, 0);
        repeat (2) @(negedge clk);

        // Reset during WAIT_DONE aborts; held request is re-granted afterwards.
        busy_len = 6;
        set_op(0, 8'd6, 8'd13);
        req   = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (div_busy && !div_start && gnt == 4'b0001) found = 1'b1;
        end
        check("reach_wait_done", 32'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_gnt", 32'(gnt), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_start", 32'(div_start), 0);
        check("midrst_opnd", {div_m, div_q}, 0);
        check("midrst_res", {res_quo, res_rem}, 0);
        check("midrst_err", 32'(err), 0);
        reset = 1'b0;
        push(0, 8'd2, 8'd1, 1'b0);
        run_ops(1, 1'b1, lat);
        repeat (2) @(negedge clk);

        // Zero divisor.
        set_op(3, 8'd0, 8'd9);
        r0 = n_rise;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
        push(3, 8'd255, 8'd9, 1'b1);
        req = 4'b1000;
        run_ops(1, 1'b1, lat);
        check("zero_no_start", n_rise - r0, 0);
`else
        push(3, 8'd255, 8'd9, 1'b0);
        req = 4'b1000;
        run_ops(1, 1'b1, lat);
        check("zero_start", n_rise - r0, 1);
`endif
        repeat (2) @(negedge clk);

        // Divider slow to raise busy: start must be held until busy is seen.
        busy_dly = 3;
        busy_len = 4;
        set_op(1, 8'd7, 8'd50);
        push(1, 8'd7, 8'd1, 1'b0);
        r0  = n_rise;
        h0  = n_start_hi;
        a0  = n_accept;
        req = 4'b0010;
        run_ops(1, 1'b1, lat);
        check("stall_start_rise", n_rise - r0, 1);
        check("stall_accept", n_accept - a0, 1);
        check("stall_start_hi", n_start_hi - h0, 4);
        busy_dly = 1;
        repeat (3) @(negedge clk);
        check("res_hold_quo", 32'(res_quo), 7);
        check("res_hold_rem", 32'(res_rem), 1);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
